// File: rtl/board_io_pkg.sv
// Shared types and constants for the board IO bridge: LCD sequencer states,
// the LCD command snapshot and bit positions inside the core's IO words.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // Field positions inside the core's LCD word
  localparam int LCD_DATA_LSB = 0;
  localparam int LCD_DATA_MSB = 7;
  localparam int LCD_RW_BIT   = 8;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_REQ_BIT  = 10;
  localparam int LCD_ON_BIT   = 31;

  // Position of the busy flag in the switch word returned to the core
  localparam int SW_BUSY_BIT  = 31;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single switch conditioner: two-flop synchroniser followed by a stability
// counter. The accepted level only follows the pin after it has held a new
// level for DB_CYC consecutive synchronised samples.
module sw_debounce #(
  parameter int DB_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic sw_o
);

  localparam int CNT_W = (DB_CYC < 1) ? 1 : $clog2(DB_CYC + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             acc_q;
  logic             acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count mismatching samples; toggle the accepted level once the run is long enough
  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    if (sync2_q != acc_q) begin
      if (cnt_q >= CNT_W'(DB_CYC - 1)) begin
        acc_d = ~acc_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, stability counter and accepted level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign sw_o = acc_q;

endmodule

// File: rtl/board_io_bridge.sv
// Registered bridge between the core's memory-mapped IO words and the board
// pins: debounced switches, LED/HEX copies, an HD44780 strobe sequencer with
// a one-entry pending buffer, and a sticky protocol-error flag.
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int SW_W           = 17,
  parameter int LEDR_W         = 17,
  parameter int LEDG_W         = 8,
  parameter int NUM_HEX        = 8,
  parameter bit HEX_ACTIVE_LOW = 1'b1,
  parameter int DB_CYC         = 500000,
  parameter int LCD_SETUP_CYC  = 3,
  parameter int LCD_EN_CYC     = 25,
  parameter int LCD_HOLD_CYC   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [SW_W-1:0]         sw_i,
  output logic [31:0]             io_sw_o,
  input  logic [31:0]             io_lcd_i,
  input  logic [31:0]             io_ledg_i,
  input  logic [31:0]             io_ledr_i,
  input  logic [NUM_HEX-1:0][31:0] io_hex_i,
  output logic [LEDG_W-1:0]       ledg_o,
  output logic [LEDR_W-1:0]       ledr_o,
  output logic [NUM_HEX-1:0][6:0] hex_o,
  output logic [7:0]              lcd_data_o,
  output logic                    lcd_rw_o,
  output logic                    lcd_rs_o,
  output logic                    lcd_en_o,
  output logic                    lcd_on_o,
  output logic                    lcd_busy_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(max3(LCD_SETUP_CYC, LCD_EN_CYC, LCD_HOLD_CYC) + 1);
  localparam logic [6:0]  HEX_INV     = {7{HEX_ACTIVE_LOW}};
  localparam logic [31:0] LEDG_UNUSED = ~(32'hFFFF_FFFF >> (32 - LEDG_W));
  localparam logic [31:0] LEDR_UNUSED = ~(32'hFFFF_FFFF >> (32 - LEDR_W));

  logic [SW_W-1:0]         sw_acc;
  logic [LEDG_W-1:0]       ledg_q;
  logic [LEDR_W-1:0]       ledr_q;
  logic [NUM_HEX-1:0][6:0] hex_q;
  logic                    lcd_on_q;
  logic                    req_prev_q;
  logic                    req;
  lcd_cmd_t                new_cmd;

  lcd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  lcd_cmd_t                cmd_q, cmd_d;
  lcd_cmd_t                pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    cnt_expired;
  logic                    overflow;
  logic                    unused_nz;
  logic                    err_q;

  for (genvar g = 0; g < SW_W; g++) begin : g_db
    sw_debounce #(
      .DB_CYC (DB_CYC)
    ) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sw_i   (sw_i[g]),
      .sw_o   (sw_acc[g])
    );
  end

  assign req          = io_lcd_i[LCD_REQ_BIT] & ~req_prev_q;
  assign new_cmd.rs   = io_lcd_i[LCD_RS_BIT];
  assign new_cmd.rw   = io_lcd_i[LCD_RW_BIT];
  assign new_cmd.data = io_lcd_i[LCD_DATA_MSB:LCD_DATA_LSB];
  assign cnt_expired  = (cnt_q <= CNT_W'(1));

  // Registered copies of the LED, HEX and LCD-on words plus the strobe edge history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledg_q     <= '0;
      ledr_q     <= '0;
      hex_q      <= {NUM_HEX{HEX_INV}};
      lcd_on_q   <= 1'b0;
      req_prev_q <= 1'b0;
    end else begin
      ledg_q     <= io_ledg_i[LEDG_W-1:0];
      ledr_q     <= io_ledr_i[LEDR_W-1:0];
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= io_hex_i[i][6:0] ^ HEX_INV;
      lcd_on_q   <= io_lcd_i[LCD_ON_BIT];
      req_prev_q <= io_lcd_i[LCD_REQ_BIT];
    end
  end

  // Any set bit outside the defined fields of the core words is a protocol error
  always_comb begin
    unused_nz = (|io_lcd_i[LCD_ON_BIT-1:LCD_REQ_BIT+1])
              | (|(io_ledg_i & LEDG_UNUSED))
              | (|(io_ledr_i & LEDR_UNUSED));
    for (int i = 0; i < NUM_HEX; i++) unused_nz = unused_nz | (|io_hex_i[i][31:7]);
  end

  // LCD sequencer next state, command snapshot, pending buffer and overflow detection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overflow     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          cmd_d   = pend_q;
          state_d = SETUP;
          cnt_d   = CNT_W'(LCD_SETUP_CYC);
          if (req) pend_d = new_cmd;
          else     pend_valid_d = 1'b0;
        end else if (req) begin
          cmd_d   = new_cmd;
          state_d = SETUP;
          cnt_d   = CNT_W'(LCD_SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt_expired) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(LCD_EN_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_expired) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(LCD_HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_expired) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && req) begin
      if (!pend_valid_q) begin
        pend_d       = new_cmd;
        pend_valid_d = 1'b1;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  // Sequencer state, LCD pin registers, pending entry and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      err_q        <= err_q | unused_nz | overflow;
    end
  end

  // Switch word returned to the core: busy flag on top, debounced switches at the bottom
  always_comb begin
    io_sw_o              = '0;
    io_sw_o[SW_W-1:0]    = sw_acc;
    io_sw_o[SW_BUSY_BIT] = lcd_busy_o;
  end

  assign ledg_o     = ledg_q;
  assign ledr_o     = ledr_q;
  assign hex_o      = hex_q;
  assign lcd_data_o = cmd_q.data;
  assign lcd_rs_o   = cmd_q.rs;
  assign lcd_rw_o   = cmd_q.rw;
  assign lcd_en_o   = (state_q == PULSE);
  assign lcd_on_o   = lcd_on_q;
  assign lcd_busy_o = (state_q != IDLE) | pend_valid_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// Self-checking bench for board_io_bridge with short debounce and LCD timing.
// A cycle-indexed reference model (sample history for the switches, strobe
// start timestamps for the LCD) predicts every output.
module tb_board_io_bridge;

  localparam int SW_W    = 17;
  localparam int LEDR_W  = 17;
  localparam int LEDG_W  = 8;
  localparam int NUM_HEX = 8;
  localparam int DB      = 8;
  localparam int SU      = 2;
  localparam int EN      = 4;
  localparam int HO      = 2;
  localparam int TOTAL   = SU + EN + HO;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [SW_W-1:0]         sw_i = '0;
  logic [31:0]             io_sw_o;
  logic [31:0]             io_lcd_i = '0;
  logic [31:0]             io_ledg_i = '0;
  logic [31:0]             io_ledr_i = '0;
  logic [NUM_HEX-1:0][31:0] io_hex_i = '0;
  logic [LEDG_W-1:0]       ledg_o;
  logic [LEDR_W-1:0]       ledr_o;
  logic [NUM_HEX-1:0][6:0] hex_o;
  logic [7:0]              lcd_data_o;
  logic                    lcd_rw_o, lcd_rs_o, lcd_en_o, lcd_on_o, lcd_busy_o, err_o;

  int checks = 0;
  int passes = 0;

  // Reference model state; n is the index of the next active clock edge
  int                      n;
  logic [SW_W-1:0]         hist[$];
  logic [SW_W-1:0]         m_acc;
  int                      m_start;
  logic [9:0]              m_cur, m_pend;
  bit                      m_pv, m_err, m_prev10, m_on;
  logic [LEDG_W-1:0]       m_ledg;
  logic [LEDR_W-1:0]       m_ledr;
  logic [NUM_HEX-1:0][6:0] m_hex;

  board_io_bridge #(
    .SW_W(SW_W), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W), .NUM_HEX(NUM_HEX),
    .HEX_ACTIVE_LOW(1'b1), .DB_CYC(DB),
    .LCD_SETUP_CYC(SU), .LCD_EN_CYC(EN), .LCD_HOLD_CYC(HO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_i(sw_i), .io_sw_o(io_sw_o),
    .io_lcd_i(io_lcd_i), .io_ledg_i(io_ledg_i), .io_ledr_i(io_ledr_i),
    .io_hex_i(io_hex_i), .ledg_o(ledg_o), .ledr_o(ledr_o), .hex_o(hex_o),
    .lcd_data_o(lcd_data_o), .lcd_rw_o(lcd_rw_o), .lcd_rs_o(lcd_rs_o),
    .lcd_en_o(lcd_en_o), .lcd_on_o(lcd_on_o), .lcd_busy_o(lcd_busy_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // EN is high after edge e when e lies in [start+SU, start+SU+EN)
  function automatic bit m_en();
    int e;
    e = n - 1;
    return (e >= m_start + SU) && (e < m_start + SU + EN);
  endfunction

  function automatic bit m_busy();
    int e;
    e = n - 1;
    return (e < m_start + TOTAL) || m_pv;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 16; i++) hist.push_back('0);
    m_acc = '0; m_start = -100; m_cur = '0; m_pend = '0;
    m_pv = 0; m_err = 0; m_prev10 = 0; m_on = 0;
    m_ledg = '0; m_ledr = '0; m_hex = {NUM_HEX{7'h7F}};
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic model_edge();
    bit req, idle, all_diff;
    hist.push_back(sw_i);
    for (int b = 0; b < SW_W; b++) begin
      all_diff = 1;
      for (int k = 0; k < DB; k++)
        if (hist[hist.size() - 3 - k][b] == m_acc[b]) all_diff = 0;
      if (all_diff) m_acc[b] = ~m_acc[b];
    end
    if (hist.size() > 32) void'(hist.pop_front());
    m_ledg = io_ledg_i[LEDG_W-1:0];
    m_ledr = io_ledr_i[LEDR_W-1:0];
    for (int i = 0; i < NUM_HEX; i++) m_hex[i] = ~io_hex_i[i][6:0];
    if ((io_ledg_i >> LEDG_W) != 0 || (io_ledr_i >> LEDR_W) != 0 || io_lcd_i[30:11] != 0) m_err = 1;
    for (int i = 0; i < NUM_HEX; i++) if (io_hex_i[i][31:7] != 0) m_err = 1;
    req = io_lcd_i[10] && !m_prev10;
    m_prev10 = io_lcd_i[10];
    m_on = io_lcd_i[31];
    idle = (n > m_start + TOTAL);
    if (idle) begin
      if (m_pv) begin
        m_cur = m_pend; m_start = n;
        if (req) m_pend = io_lcd_i[9:0];
        else     m_pv = 0;
      end else if (req) begin
        m_cur = io_lcd_i[9:0]; m_start = n;
      end
    end else if (req) begin
      if (!m_pv) begin m_pv = 1; m_pend = io_lcd_i[9:0]; end
      else m_err = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_i);
    #1;
    n++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    sw_i = '0; io_lcd_i = '0; io_ledg_i = '0; io_ledr_i = '0; io_hex_i = '0;
    #2;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    sw_i = '1;
    io_ledg_i = $urandom & 32'hFF;
    for (int i = 0; i < NUM_HEX; i++) io_hex_i[i] = $urandom & 32'h7F;
    for (int i = 0; i < 12; i++) step();
    checks++; if (io_sw_o[SW_W-1:0] !== {SW_W{1'b1}}) $display("[TB] FAIL pre_reset_sw: got %h expected %h", io_sw_o[SW_W-1:0], {SW_W{1'b1}}); else passes++;
    io_lcd_i = 32'h8000_0455; step();
    io_lcd_i = 32'h8000_0055; step();
    io_lcd_i = 32'h8000_0466; step();
    checks++; if (lcd_en_o !== 1'b1) $display("[TB] FAIL pre_reset_en: got %b expected 1", lcd_en_o); else passes++;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (lcd_en_o !== 1'b0) $display("[TB] FAIL reset_en: got %b expected 0", lcd_en_o); else passes++;
    checks++; if (lcd_busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", lcd_busy_o); else passes++;
    checks++; if (io_sw_o !== 32'h0) $display("[TB] FAIL reset_io_sw: got %h expected 0", io_sw_o); else passes++;
    checks++; if (hex_o !== {NUM_HEX{7'h7F}}) $display("[TB] FAIL reset_hex: got %h expected all 7F", hex_o); else passes++;
    checks++; if ({ledg_o, ledr_o} !== '0) $display("[TB] FAIL reset_leds: got %h expected 0", {ledg_o, ledr_o}); else passes++;
    checks++; if ({lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_on_o, err_o} !== '0) $display("[TB] FAIL reset_lcd_err: got %h expected 0", {lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_on_o, err_o}); else passes++;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (lcd_busy_o !== 1'b0 || lcd_en_o !== 1'b0) $display("[TB] FAIL pending_discarded: busy=%b en=%b expected 0 0", lcd_busy_o, lcd_en_o); else passes++;
    end
  endtask

  task automatic test_debounce();
    do_reset();
    sw_i[3] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9) begin
        checks++; if (io_sw_o[3] !== 1'b0) $display("[TB] FAIL db_early: got %b expected 0", io_sw_o[3]); else passes++;
      end
      if (i == 10) begin
        checks++; if (io_sw_o[3] !== 1'b1) $display("[TB] FAIL db_latency: got %b expected 1", io_sw_o[3]); else passes++;
      end
    end
    sw_i[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) sw_i[0] = 1'b0;
      step();
      checks++; if (io_sw_o[0] !== 1'b0) $display("[TB] FAIL db_glitch: got %b expected 0", io_sw_o[0]); else passes++;
    end
    checks++; if (io_sw_o[3] !== 1'b1) $display("[TB] FAIL db_hold: got %b expected 1", io_sw_o[3]); else passes++;
  endtask

  task automatic test_debounce_random();
    logic [31:0] exp;
    int c, r;
    do_reset();
    c = 0;
    while (c < 320) begin
      sw_i = SW_W'($urandom);
      r = $urandom_range(1, 14);
      for (int j = 0; j < r; j++) begin
        step();
        c++;
        exp = '0;
        exp[SW_W-1:0] = m_acc;
        exp[31] = m_busy();
        checks++; if (io_sw_o !== exp) $display("[TB] FAIL db_random: got %h expected %h", io_sw_o, exp); else passes++;
      end
    end
  endtask

  task automatic test_lcd_single();
    bit en_exp, busy_exp;
    do_reset();
    io_lcd_i = 32'h8000_0241; step();
    checks++; if (lcd_on_o !== 1'b1 || lcd_busy_o !== 1'b0) $display("[TB] FAIL single_pre: on=%b busy=%b expected 1 0", lcd_on_o, lcd_busy_o); else passes++;
    io_lcd_i = 32'h8000_0641; step();
    checks++; if ({lcd_rs_o, lcd_rw_o, lcd_data_o} !== {2'b10, 8'h41}) $display("[TB] FAIL single_snapshot: got %h expected %h", {lcd_rs_o, lcd_rw_o, lcd_data_o}, {2'b10, 8'h41}); else passes++;
    checks++; if (lcd_en_o !== 1'b0 || lcd_busy_o !== 1'b1) $display("[TB] FAIL single_start: en=%b busy=%b expected 0 1", lcd_en_o, lcd_busy_o); else passes++;
    io_lcd_i = 32'h8000_0241;
    for (int k = 1; k <= 10; k++) begin
      step();
      en_exp   = (k >= 2 && k <= 5);
      busy_exp = (k < 8);
      checks++; if (lcd_en_o !== en_exp) $display("[TB] FAIL single_en k=%0d: got %b expected %b", k, lcd_en_o, en_exp); else passes++;
      checks++; if (lcd_busy_o !== busy_exp || io_sw_o[31] !== busy_exp) $display("[TB] FAIL single_busy k=%0d: busy=%b sw31=%b expected %b", k, lcd_busy_o, io_sw_o[31], busy_exp); else passes++;
      if (k == 7) begin
        checks++; if (lcd_data_o !== 8'h41) $display("[TB] FAIL single_hold_data: got %h expected 41", lcd_data_o); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6];
    bit en_exp, busy_exp, err_exp;
    logic [7:0] data_exp;
    words = '{32'h8000_0441, 32'h8000_0041, 32'h8000_0041, 32'h8000_0442, 32'h8000_0042, 32'h8000_0443};
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      io_lcd_i = (k < 6) ? words[k] : 32'h8000_0043;
      step();
      en_exp   = (k >= 2 && k <= 5) || (k >= 11 && k <= 14);
      busy_exp = (k < 17);
      err_exp  = (k >= 5);
      data_exp = (k < 9) ? 8'h41 : 8'h42;
      checks++; if (lcd_en_o !== en_exp) $display("[TB] FAIL b2b_en k=%0d: got %b expected %b", k, lcd_en_o, en_exp); else passes++;
      checks++; if (lcd_busy_o !== busy_exp) $display("[TB] FAIL b2b_busy k=%0d: got %b expected %b", k, lcd_busy_o, busy_exp); else passes++;
      checks++; if (err_o !== err_exp) $display("[TB] FAIL b2b_err k=%0d: got %b expected %b", k, err_o, err_exp); else passes++;
      checks++; if (lcd_data_o !== data_exp) $display("[TB] FAIL b2b_data k=%0d: got %h expected %h", k, lcd_data_o, data_exp); else passes++;
    end
  endtask

  task automatic test_hex_led();
    int f, bitpos, dig;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      io_ledg_i = $urandom & 32'hFF;
      io_ledr_i = $urandom & 32'h1FFFF;
      for (int i = 0; i < NUM_HEX; i++) io_hex_i[i] = $urandom & 32'h7F;
      step();
      checks++; if (ledg_o !== m_ledg || ledr_o !== m_ledr) $display("[TB] FAIL led_copy: got %h/%h expected %h/%h", ledg_o, ledr_o, m_ledg, m_ledr); else passes++;
      checks++; if (hex_o !== m_hex) $display("[TB] FAIL hex_copy: got %h expected %h", hex_o, m_hex); else passes++;
      checks++; if (err_o !== m_err) $display("[TB] FAIL led_err_clean: got %b expected %b", err_o, m_err); else passes++;
    end
    io_hex_i[5] = 32'h0000_0006; step();
    checks++; if (hex_o[5] !== 7'h79) $display("[TB] FAIL hex5_digit: got %h expected 79", hex_o[5]); else passes++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL hex5_err: got %b expected 0", err_o); else passes++;
    io_ledr_i = 32'h0002_0000; step();
    checks++; if (ledr_o !== '0) $display("[TB] FAIL ledr_unused: got %h expected 0", ledr_o); else passes++;
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL ledr_err: got %b expected 1", err_o); else passes++;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      step();
      checks++; if (err_o !== 1'b0) $display("[TB] FAIL inject_pre t=%0d: got %b expected 0", t, err_o); else passes++;
      f = $urandom_range(0, 3);
      case (f)
        0: begin bitpos = $urandom_range(11, 30); io_lcd_i[bitpos] = 1'b1; end
        1: begin dig = $urandom_range(0, NUM_HEX - 1); bitpos = $urandom_range(7, 31); io_hex_i[dig][bitpos] = 1'b1; end
        2: begin bitpos = $urandom_range(LEDG_W, 31); io_ledg_i[bitpos] = 1'b1; end
        default: begin bitpos = $urandom_range(LEDR_W, 31); io_ledr_i[bitpos] = 1'b1; end
      endcase
      step();
      checks++; if (err_o !== 1'b1) $display("[TB] FAIL inject_set t=%0d field=%0d: got %b expected 1", t, f, err_o); else passes++;
      io_lcd_i = '0; io_hex_i = '0; io_ledg_i = '0; io_ledr_i = '0;
      step();
      checks++; if (err_o !== 1'b1) $display("[TB] FAIL inject_sticky t=%0d: got %b expected 1", t, err_o); else passes++;
    end
  endtask

  task automatic test_random_lcd();
    logic [31:0] w;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      w = '0;
      w[9:0] = 10'($urandom);
      w[31] = 1'($urandom);
      w[10] = ($urandom_range(0, 3) == 0) ? ~io_lcd_i[10] : io_lcd_i[10];
      io_lcd_i = w;
      step();
      checks++; if (lcd_en_o !== m_en()) $display("[TB] FAIL rnd_en c=%0d: got %b expected %b", c, lcd_en_o, m_en()); else passes++;
      checks++; if (lcd_busy_o !== m_busy() || io_sw_o[31] !== m_busy()) $display("[TB] FAIL rnd_busy c=%0d: busy=%b sw31=%b expected %b", c, lcd_busy_o, io_sw_o[31], m_busy()); else passes++;
      checks++; if ({lcd_rs_o, lcd_rw_o, lcd_data_o} !== m_cur) $display("[TB] FAIL rnd_cmd c=%0d: got %h expected %h", c, {lcd_rs_o, lcd_rw_o, lcd_data_o}, m_cur); else passes++;
      checks++; if (lcd_on_o !== m_on || err_o !== m_err) $display("[TB] FAIL rnd_on_err c=%0d: on=%b err=%b expected %b %b", c, lcd_on_o, err_o, m_on, m_err); else passes++;
    end
  endtask

  initial begin
    $display("[TB] board_io_bridge bench start");
    test_reset();
    test_debounce();
    test_debounce_random();
    test_lcd_single();
    test_back_to_back();
    test_hex_led();
    test_random_lcd();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
